// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer line prefetcher: geometry defaults,
// fill FSM encoding and the value returned on a client miss.
package fb_pkg;

    localparam int LINE_W_DEF  = 320;
    localparam int LINES_DEF   = 240;
    localparam int FB_BASE_DEF = 0;

    localparam logic [15:0] MISS_DATA = 16'h0000;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_INIT0,
        ST_INIT1,
        ST_IDLE,
        ST_FILL
    } fill_state_e;

    function automatic logic is_filling(fill_state_e s);
        return (s == ST_INIT0) || (s == ST_INIT1) || (s == ST_FILL);
    endfunction

endpackage

// File: rtl/fb_line_ram.sv
// Two LINE_W x 8 line banks, simple dual-port: fill path writes, client reads
// through a registered, enable-gated read port that holds its last value.
module fb_line_ram #(
    parameter int LINE_W = 320,
    parameter int COL_W  = 9
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic             wr_bank_i,
    input  logic [COL_W-1:0] wr_col_i,
    input  logic [7:0]       wr_data_i,
    input  logic             rd_en_i,
    input  logic             rd_bank_i,
    input  logic [COL_W-1:0] rd_col_i,
    output logic [7:0]       rd_data_o
);

    localparam int DEPTH = 2 * LINE_W;
    localparam int IDX_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       rd_data_q;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign wr_idx = (wr_bank_i ? IDX_W'(LINE_W) : '0) + IDX_W'(wr_col_i);
    assign rd_idx = (rd_bank_i ? IDX_W'(LINE_W) : '0) + IDX_W'(rd_col_i);

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fb_line_prefetch.sv
// Framebuffer read front-end: two prefetched line banks answer client reads with
// fixed two-cycle latency. Define FB_PREFETCH_STATS_EN to add the oMissCount port.
module fb_line_prefetch
    import fb_pkg::*;
#(
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 16,
    parameter int LINE_W    = LINE_W_DEF,
    parameter int LINES     = LINES_DEF,
    parameter int FB_BASE   = FB_BASE_DEF,
    parameter int MAX_OUTST = 8
) (
    input  logic              sdram_clk,
    input  logic              iRST_n,
    input  logic              iRead,
    input  logic [ADDR_W-1:0] iAddress,
    output logic [DATA_W-1:0] oReaddata,
    output logic              oDone,
    output logic [ADDR_W-1:0] oAvs_address,
    output logic              oAvs_read,
    input  logic              iAvs_waitrequest,
    input  logic [DATA_W-1:0] iAvs_readdata,
    input  logic              iAvs_readdatavalid
`ifdef FB_PREFETCH_STATS_EN
    ,
    output logic [15:0]       oMissCount
`endif
);

    localparam int COL_W = $clog2(LINE_W + 1);
    localparam int ROW_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int OUT_W = $clog2(MAX_OUTST + 1);

    localparam logic [COL_W-1:0]  LINE_W_C   = COL_W'(LINE_W);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(LINES - 1);
    localparam logic [OUT_W-1:0]  MAX_OUT_C  = OUT_W'(MAX_OUTST);
    localparam logic [ADDR_W-1:0] NPIX_C     = ADDR_W'(LINE_W * LINES);
    localparam logic [ADDR_W-1:0] LINE_W_A   = ADDR_W'(LINE_W);

    fill_state_e      state_q;
    logic [ROW_W-1:0] tag_q [2];
    logic [1:0]       valid_q;
    logic             done_q;
    logic             fill_bank_q;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [COL_W-1:0] issue_col_q, issue_col_d;
    logic [COL_W-1:0] ret_col_q, ret_col_d;
    logic [OUT_W-1:0] outst_q, outst_d;

    logic             filling, accept, beat, fill_done;

    // Stage p0: client decode against the current bank tags
    logic [ADDR_W-1:0] row_full, col_full;
    logic [ROW_W-1:0]  row_p0, next_row_p0;
    logic [COL_W-1:0]  col_p0;
    logic              in_range_p0, hit0_p0, hit1_p0, hit_p0, bank_p0, trig_p0;

    assign row_full    = iAddress / LINE_W_A;
    assign col_full    = iAddress % LINE_W_A;
    assign row_p0      = ROW_W'(row_full);
    assign col_p0      = COL_W'(col_full);
    assign in_range_p0 = iAddress < NPIX_C;
    assign hit0_p0     = in_range_p0 && valid_q[0] && (tag_q[0] == row_p0);
    assign hit1_p0     = in_range_p0 && valid_q[1] && (tag_q[1] == row_p0);
    assign hit_p0      = iRead && (hit0_p0 || hit1_p0);
    assign bank_p0     = hit1_p0;
    assign next_row_p0 = (row_p0 == LAST_ROW) ? '0 : row_p0 + ROW_W'(1);
    assign trig_p0     = hit_p0 && (state_q == ST_IDLE) && (tag_q[~bank_p0] != next_row_p0);

    // Stage p1: registered decode drives the RAM read address
    logic             vld_p1_q, hit_p1_q, bank_p1_q;
    logic [COL_W-1:0] col_p1_q;
    // Stage p2: RAM output register and its hit qualifier
    logic             hit_p2_q;
    logic [7:0]       rd_data_p2;

    always_ff @(posedge sdram_clk) begin
        if (!iRST_n) begin
            vld_p1_q <= 1'b0;
            hit_p1_q <= 1'b0;
            hit_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= iRead;
            hit_p1_q <= hit_p0;
            if (vld_p1_q) begin
                hit_p2_q <= hit_p1_q;
            end
        end
    end

    always_ff @(posedge sdram_clk) begin
        bank_p1_q <= bank_p0;
        col_p1_q  <= col_p0;
    end

    assign oReaddata = hit_p2_q ? {{(DATA_W-8){1'b0}}, rd_data_p2} : DATA_W'(MISS_DATA);

    // Fill datapath: Avalon issue/return counters
    assign filling   = is_filling(state_q);
    assign oAvs_read = filling && (issue_col_q < LINE_W_C) && (outst_q < MAX_OUT_C);
    assign accept    = oAvs_read && !iAvs_waitrequest;
    assign beat      = filling && iAvs_readdatavalid && (ret_col_q < LINE_W_C);
    assign fill_done = filling && (ret_col_q == LINE_W_C);

    always_comb begin
        issue_col_d = issue_col_q + COL_W'(accept);
        fill_addr_d = fill_addr_q + ADDR_W'(accept);
        ret_col_d   = ret_col_q + COL_W'(beat);
        outst_d     = outst_q + OUT_W'(accept) - OUT_W'(beat);
    end

    assign oAvs_address = oAvs_read ? fill_addr_q : '0;
    assign oDone        = done_q;

    always_ff @(posedge sdram_clk) begin
        if (!iRST_n) begin
            state_q     <= ST_RESET;
            tag_q[0]    <= '0;
            tag_q[1]    <= '0;
            valid_q     <= 2'b00;
            done_q      <= 1'b0;
            fill_bank_q <= 1'b0;
            fill_addr_q <= ADDR_W'(FB_BASE);
            issue_col_q <= '0;
            ret_col_q   <= '0;
            outst_q     <= '0;
        end else begin
            issue_col_q <= issue_col_d;
            fill_addr_q <= fill_addr_d;
            ret_col_q   <= ret_col_d;
            outst_q     <= outst_d;
            case (state_q)
                ST_RESET: begin
                    state_q     <= ST_INIT0;
                    fill_bank_q <= 1'b0;
                    fill_addr_q <= ADDR_W'(FB_BASE);
                end
                ST_INIT0: begin
                    if (fill_done) begin
                        valid_q[0]  <= 1'b1;
                        tag_q[1]    <= ROW_W'(1);
                        fill_bank_q <= 1'b1;
                        fill_addr_q <= ADDR_W'(FB_BASE + LINE_W);
                        issue_col_q <= '0;
                        ret_col_q   <= '0;
                        outst_q     <= '0;
                        state_q     <= ST_INIT1;
                    end
                end
                ST_INIT1: begin
                    if (fill_done) begin
                        valid_q[1]  <= 1'b1;
                        done_q      <= 1'b1;
                        issue_col_q <= '0;
                        ret_col_q   <= '0;
                        outst_q     <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (trig_p0) begin
                        // The bank being refilled must stop answering hits immediately.
                        tag_q[~bank_p0]   <= next_row_p0;
                        valid_q[~bank_p0] <= 1'b0;
                        fill_bank_q       <= ~bank_p0;
                        fill_addr_q       <= ADDR_W'(FB_BASE + int'(next_row_p0) * LINE_W);
                        issue_col_q       <= '0;
                        ret_col_q         <= '0;
                        outst_q           <= '0;
                        state_q           <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (fill_done) begin
                        valid_q[fill_bank_q] <= 1'b1;
                        issue_col_q          <= '0;
                        ret_col_q            <= '0;
                        outst_q              <= '0;
                        state_q              <= ST_IDLE;
                    end
                end
                default: state_q <= ST_RESET;
            endcase
        end
    end

    fb_line_ram #(
        .LINE_W (LINE_W),
        .COL_W  (COL_W)
    ) u_ram (
        .clk_i     (sdram_clk),
        .wr_en_i   (beat),
        .wr_bank_i (fill_bank_q),
        .wr_col_i  (ret_col_q),
        .wr_data_i (iAvs_readdata[7:0]),
        .rd_en_i   (vld_p1_q),
        .rd_bank_i (bank_p1_q),
        .rd_col_i  (col_p1_q),
        .rd_data_o (rd_data_p2)
    );

`ifdef FB_PREFETCH_STATS_EN
    function automatic logic [15:0] sat_inc16(logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] miss_cnt_q;

    always_ff @(posedge sdram_clk) begin
        if (!iRST_n) begin
            miss_cnt_q <= '0;
        end else if (vld_p1_q && !hit_p1_q) begin
            miss_cnt_q <= sat_inc16(miss_cnt_q);
        end
    end

    assign oMissCount = miss_cnt_q;
`endif

    logic unused_bits;
    assign unused_bits = ^{iAvs_readdata[DATA_W-1:8], row_full, col_full};

endmodule

// File: doc/fb_line_prefetch.md
# fb_line_prefetch

Framebuffer read front-end between the SDRAM controller's Avalon-MM read port and the VGA pixel fetcher. Holds two 320-pixel line banks, filled by burst-free pipelined SDRAM reads, and answers the fetcher's single-cycle read strobes from on-chip RAM with a fixed two-cycle latency. This removes SDRAM latency jitter from the pixel path. `oDone` gates the fetcher until the first two rows are resident.

## Interface
Parameters:
- `ADDR_W`, 25: SDRAM word address width.
- `DATA_W`, 16: SDRAM data width. Pixel index is `[7:0]`; upper bits are stored as zero.
- `LINE_W`, 320: pixels per framebuffer row.
- `LINES`, 240: rows per frame.
- `FB_BASE`, 0: word address of pixel 0.
- `MAX_OUTST`, 8: maximum in-flight SDRAM reads.

Ports (reset `iRST_n` is synchronous, active-low; clock is `sdram_clk`):
- `sdram_clk` in 1: single clock domain.
- `iRST_n` in 1: synchronous active-low reset.
- `iRead` in 1: client read strobe, one cycle.
- `iAddress` in ADDR_W: pixel address relative to `FB_BASE`; stable in the strobe cycle.
- `oReaddata` out DATA_W: `{8'h00, index}`.
- `oDone` out 1: initial fill complete.
- `oAvs_address` out ADDR_W: SDRAM read address.
- `oAvs_read` out 1: SDRAM read request.
- `iAvs_waitrequest` in 1: SDRAM stall.
- `iAvs_readdata` in DATA_W: SDRAM return data.
- `iAvs_readdatavalid` in 1: SDRAM return strobe.
- `oMissCount` out 16: present only with `FB_PREFETCH_STATS_EN`.

## Operation
- Each of the two banks carries a `tag` (row number) and a `valid` bit.
- Client decode: `row = iAddress / LINE_W`, `col = iAddress % LINE_W` (constant divide).
- Hit: the row equals the tag of a valid bank.
- Miss: the row is out of range (`iAddress >= LINE_W*LINES`), or the row is not resident, or the row is being filled. A miss returns `16'h0000`.
- Fill FSM states:
  - `RESET`: unconditional next state is `INIT0`.
  - `INIT0`: fills row 0 into bank 0, then goes to `INIT1`.
  - `INIT1`: fills row 1 into bank 1, then goes to `IDLE`; `oDone` rises on this transition.
  - `IDLE`: waits for a trigger, then goes to `FILL`.
  - `FILL`: issues reads and collects returns, then goes to `IDLE`.
- Trigger: a client hit on row R in bank b while the FSM is in `IDLE`, and the other bank's tag is not `(R+1) mod LINES`. The fill then targets the other bank with `row = (R+1) mod LINES`. The other bank's `valid` is cleared on the trigger cycle and its tag is set to the new row.
- Row wrap: after a hit on row `LINES-1`, row 0 is prefetched.
- Fill issue:
  - `oAvs_address = FB_BASE + row*LINE_W + issue_col`.
  - `oAvs_read` is held while `issue_col < LINE_W` and `outst < MAX_OUTST`.
  - `issue_col` advances only on a cycle with `oAvs_read && !iAvs_waitrequest`.
  - `outst` increments on accept and decrements on `iAvs_readdatavalid`. Both in the same cycle leaves it unchanged.
- Fill returns: they arrive in order. `ret_col` increments per beat and writes `iAvs_readdata[7:0]` into bank[`ret_col`].
- Fill completes when `ret_col == LINE_W`. On that cycle `valid` is set and the FSM goes to `IDLE`.
- `readdatavalid` while not in `INIT0`/`INIT1`/`FILL`: ignored. The SDRAM controller shares `iRST_n`, so no stale beats are expected.
- Reset at any time clears everything:
  - Both tags are set to 0 and both `valid` bits are cleared.
  - `oDone`, `oAvs_read` and `oReaddata` are driven to 0.
  - `outst`, `issue_col` and `ret_col` are cleared.
  - The FSM goes to `RESET`.

## Timing
- Client latency: strobe in cycle N. Decode and RAM address are registered at N+1. `oReaddata` is valid at the start of N+2 and held until the next strobe's N+2.
- Back-to-back strobes: one every 2 cycles or slower is guaranteed. A strobe every cycle is also correct (fully pipelined).
- A hit that lands on the same cycle as the completion of that bank's fill counts as a miss. A hit on the cycle after completion is served.
- Initial fill takes ≥ 2·LINE_W cycles. The minimum is 642 cycles with zero-latency SDRAM.
- Reset values:
  - `oReaddata` = 0.
  - `oDone` = 0.
  - `oAvs_read` = 0.
  - `oAvs_address` = 0.
  - `oMissCount` = 0.

## Configuration
- `FB_PREFETCH_STATS_EN` defined:
  - `oMissCount` exists.
  - It increments once per missed client strobe and saturates at `16'hFFFF`.
  - It is cleared by reset only.
- Not defined: the port and counter are absent, and miss behaviour is otherwise identical.

## Structure
- Shared package `fb_pkg`:
  - Defaults for `LINE_W`, `LINES` and `FB_BASE`.
  - The fill FSM state enum.
  - The `MISS_DATA` constant (`16'h0000`).
- Sub-module `fb_line_ram`:
  - Two banks of `LINE_W` × 8 bits, simple dual-port.
  - Write port owned by the fill path; read port owned by the client.
  - Registered read.

## Test plan
- Reset, SDRAM with 3-cycle latency and no waitrequest, memory word = address & 8'hFF → `oDone` rises after rows 0 and 1 are filled; exactly 640 accepted reads at addresses 0..639; `oAvs_read` is 0 afterwards.
- After `oDone`, strobe at address 325 → `oReaddata` = `16'h0045` exactly 2 cycles after the strobe; a fill of row 2 starts into bank 0 within 1 cycle.
- `iAvs_waitrequest` toggled randomly (50%) during a fill → `outst` never exceeds 8; all 320 bytes land in the correct columns; no address is skipped or repeated.
- Read row 239 → row 0 is prefetched (addresses 0..319); a subsequent read at address 0 hits.
- Read of the row under fill, and an out-of-range address 76800 → `16'h0000` is returned; with the macro, `oMissCount` = 2.
- Assert `iRST_n` = 0 mid-fill for 1 cycle → all outputs return to reset values the next cycle; the initial fill restarts at address 0.
